// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the push-button front end.
//   - key_state_t   : debounce FSM state encoding
//   - ms_to_cyc()   : converts a millisecond duration to clock cycles
//   - max_int()     : elaboration-time maximum, used to size the shared counter
//   - DEFAULT_DEBOUNCE_MS / DEFAULT_LONG_PRESS_MS : default timing parameters
//   Optional feature macro seen by users of this package: KEY_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
package key_pkg;

   localparam int DEFAULT_DEBOUNCE_MS   = 20;
   localparam int DEFAULT_LONG_PRESS_MS = 1000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   // Divide first so large clock frequencies do not overflow 32 bits.
   function automatic int ms_to_cyc(input int clk_freq_hz, input int ms);
      return (clk_freq_hz / 1000) * ms;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Generic two-flop synchronizer for asynchronous board inputs.
//   Parameters:
//     WIDTH   : number of independent single-bit signals carried
//     RST_VAL : value both flop stages take during reset
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset
//     din   : asynchronous input(s)
//     dout  : synchronized output(s), two clk cycles of latency
//   Each bit is synchronized on its own; no coherency between bits is implied.
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Debounces a raw mechanical push-button and produces clean single-cycle
//   events for the stopwatch datapath.
//   Parameters:
//     CLK_FREQ_HZ    : clock frequency in Hz
//     DEBOUNCE_MS    : stable time required before a press/release is accepted
//     LONG_PRESS_MS  : hold time that produces long_pulse (feature build only)
//     KEY_ACTIVE_LOW : 1 = raw key reads 0 while pressed
//   Ports:
//     clk           : system clock, rising edge
//     rst           : asynchronous active-low reset
//     key           : raw, asynchronous, bouncing button
//     key_level     : debounced pressed state (1 = pressed)
//     key_pulse     : one-cycle pulse on a debounced press
//     release_pulse : one-cycle pulse on a debounced release
//     long_pulse    : one-cycle pulse once per press after LONG_PRESS_MS held
//   Configuration macro: KEY_LONG_PRESS_EN
//     defined   -> long-press counting is built, long_pulse is live
//     undefined -> long-press logic is absent and long_pulse is tied to 0
// -----------------------------------------------------------------------------
module key_debounce
   import key_pkg::*;
#(
   parameter int CLK_FREQ_HZ    = 50_000_000,
   parameter int DEBOUNCE_MS    = DEFAULT_DEBOUNCE_MS,
   parameter int LONG_PRESS_MS  = DEFAULT_LONG_PRESS_MS,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic key_level,
   output logic key_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int DB_CYC = ms_to_cyc(CLK_FREQ_HZ, DEBOUNCE_MS);
   localparam int LP_CYC = ms_to_cyc(CLK_FREQ_HZ, LONG_PRESS_MS);

`ifdef KEY_LONG_PRESS_EN
   localparam int CNT_MAX = max_int(DB_CYC, LP_CYC);
`else
   localparam int CNT_MAX = DB_CYC;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   // --------------------------------------------------------------------------
   // Input conditioning: normalise to pressed = 1, then synchronize.
   // The synchronizer resets to "released" so a held button after reset still
   // has to re-qualify through the whole debounce window.
   // --------------------------------------------------------------------------
   logic key_pressed;
   logic k_s;

   assign key_pressed = KEY_ACTIVE_LOW ? ~key : key;

   sync2 #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_sync2 (
      .clk   (clk),
      .rst_n (rst),
      .din   (key_pressed),
      .dout  (k_s)
   );

   // --------------------------------------------------------------------------
   // FSM and shared counter
   // --------------------------------------------------------------------------
   key_state_t       state_q;
   key_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             key_level_q;
   logic             key_level_d;
   logic             key_pulse_q;
   logic             key_pulse_d;
   logic             release_pulse_q;
   logic             release_pulse_d;

`ifdef KEY_LONG_PRESS_EN
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LP_CYC - 1);

   logic             long_pulse_q;
   logic             long_pulse_d;
`else
   // LONG_PRESS_MS stays in the parameter list so instances are portable
   // between builds; this sink only keeps the value referenced.
   logic             lp_cfg_unused;
   assign lp_cfg_unused = (LP_CYC >= 1);
`endif

   // Saturating increment: once the counter passes LP_LAST during a long hold
   // it parks at all-ones, so the long-press compare can never match again.
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      key_pulse_d     = 1'b0;
      release_pulse_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_pulse_d    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (k_s) begin
               cnt_d   = '0;
               state_d = PRESS_WAIT;
            end
         end

         PRESS_WAIT: begin
            if (!k_s) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d     = PRESSED;
               key_pulse_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         PRESSED: begin
            if (!k_s) begin
               cnt_d   = '0;
               state_d = RELEASE_WAIT;
            end
`ifdef KEY_LONG_PRESS_EN
            else begin
               if (cnt_q == LP_LAST) begin
                  long_pulse_d = 1'b1;
               end
               cnt_d = cnt_inc;
            end
`endif
         end

         RELEASE_WAIT: begin
            if (k_s) begin
               // A bounce during release returns to PRESSED without a new
               // key_pulse; the hold time restarts from zero.
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d         = IDLE;
               release_pulse_d = 1'b1;
               cnt_d           = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Registered from the next state so the level edge lines up exactly
      // with key_pulse / release_pulse.
      key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         key_level_q     <= 1'b0;
         key_pulse_q     <= 1'b0;
         release_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         key_level_q     <= key_level_d;
         key_pulse_q     <= key_pulse_d;
         release_pulse_q <= release_pulse_d;
      end
   end

`ifdef KEY_LONG_PRESS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         long_pulse_q <= 1'b0;
      end else begin
         long_pulse_q <= long_pulse_d;
      end
   end

   assign long_pulse = long_pulse_q;
`else
   assign long_pulse = 1'b0;
`endif

   assign key_level     = key_level_q;
   assign key_pulse     = key_pulse_q;
   assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Randomized and directed stimulus for key_debounce with CLK_FREQ_HZ=1000,
//   DEBOUNCE_MS=4, LONG_PRESS_MS=20 (DB_CYC=4, LP_CYC=20), active-low key.
//   Reference model: the debounced level toggles when the raw key, as seen
//   two edges earlier through the synchronizer, has held the opposite value
//   for DB_CYC+1 consecutive samples. Expected outputs for every cycle go into
//   a queue; a monitor on the falling edge pops and compares.
//   Honours KEY_LONG_PRESS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_key_debounce;

   localparam int DB_CYC = 4;
   localparam int LP_CYC = 20;
   localparam int HLEN   = DB_CYC + 3;

   logic clk = 1'b0;
   logic rst_drv = 1'b0;
   logic key_drv = 1'b1;
   logic key_level;
   logic key_pulse;
   logic release_pulse;
   logic long_pulse;

   always #5 clk = ~clk;

   key_debounce #(
      .CLK_FREQ_HZ    (1000),
      .DEBOUNCE_MS    (4),
      .LONG_PRESS_MS  (20),
      .KEY_ACTIVE_LOW (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst_drv),
      .key           (key_drv),
      .key_level     (key_level),
      .key_pulse     (key_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse)
   );

   // ---------------- bookkeeping ----------------
   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int kp_seen = 0;
   int rp_seen = 0;
   int lp_seen = 0;
   int kp_cyc  = 0;
   int rp_cyc  = 0;
   int lp_cyc  = 0;

   logic [3:0] exp_q[$];

   // ---------------- reference model ----------------
   bit hist[HLEN];   // hist[0] = newest raw (pressed=1) sample seen by the synchronizer
   bit m_level;
   bit m_kp;
   bit m_rp;
   bit m_lp;
`ifdef KEY_LONG_PRESS_EN
   int lp_cnt;
`endif

   task automatic model_reset();
      for (int i = 0; i < HLEN; i++) hist[i] = 1'b0;
      m_level = 1'b0;
      m_kp    = 1'b0;
      m_rp    = 1'b0;
      m_lp    = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      lp_cnt  = 0;
`endif
   endtask

   task automatic model_edge(input bit s);
      bit ks;
      bit stable;
      for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s;
      m_kp = 1'b0;
      m_rp = 1'b0;
      m_lp = 1'b0;
      ks = hist[2];
      stable = 1'b1;
      for (int i = 2; i <= DB_CYC + 2; i++) if (hist[i] != ks) stable = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      // Hold time counts edges of continuous press after the debounced press;
      // any released sample restarts it, the re-entry edge counting as zero.
      if (m_level) begin
         if (ks) begin
            lp_cnt++;
            if (lp_cnt == LP_CYC) m_lp = 1'b1;
         end else begin
            lp_cnt = -1;
         end
      end
`endif
      if (stable && (ks != m_level)) begin
         m_level = ks;
         if (ks) begin
            m_kp = 1'b1;
`ifdef KEY_LONG_PRESS_EN
            lp_cnt = 0;
`endif
         end else begin
            m_rp = 1'b1;
         end
      end
   endtask

   // One clock: the edge consumes the previously driven inputs, then new
   // inputs are driven and the expected outputs for this cycle are queued.
   task automatic step(input logic k, input logic r);
      @(posedge clk);
      cyc++;
      if (!rst_drv) model_reset();
      else          model_edge(~key_drv);
      #2;
      key_drv = k;
      rst_drv = r;
      if (!r) model_reset();
      exp_q.push_back({m_level, m_kp, m_rp, m_lp});
   endtask

   task automatic hold(input logic k, input logic r, input int n);
      for (int i = 0; i < n; i++) step(k, r);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [3:0] exp_v;
      logic [3:0] act_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {key_level, key_pulse, release_pulse, long_pulse};
         n_total++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL outputs cyc=%0d: got level/kp/rp/lp=%b, expected %b",
                       cyc, act_v, exp_v);
         if (key_pulse === 1'b1) begin
            kp_seen++; kp_cyc = cyc;
            $display("cyc %0d: key_pulse (level=%b)", cyc, key_level);
         end
         if (release_pulse === 1'b1) begin
            rp_seen++; rp_cyc = cyc;
            $display("cyc %0d: release_pulse (level=%b)", cyc, key_level);
         end
         if (long_pulse === 1'b1) begin
            lp_seen++; lp_cyc = cyc;
            $display("cyc %0d: long_pulse", cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int edge_ref;
      int kp0;
      int rp0;
      int lp0;
      int budget;
      logic v;

      model_reset();

      // Reset held while the key toggles: everything must stay quiet.
      for (int i = 0; i < 8; i++) step(logic'(i % 2), 1'b0);
      settle();
      check_int("reset_quiet_pulses", kp_seen + rp_seen + lp_seen, 0);
      check_int("reset_level", int'(key_level), 0);

      hold(1'b1, 1'b1, 6);

      // Clean press.
      kp0 = kp_seen;
      edge_ref = cyc + 2;
      hold(1'b0, 1'b1, 12);
      settle();
      check_int("press_count", kp_seen - kp0, 1);
      check_int("press_latency", kp_cyc - edge_ref, DB_CYC + 2);
      check_int("press_level", int'(key_level), 1);

      // Clean release.
      rp0 = rp_seen;
      edge_ref = cyc + 2;
      hold(1'b1, 1'b1, 12);
      settle();
      check_int("release_count", rp_seen - rp0, 1);
      check_int("release_latency", rp_cyc - edge_ref, DB_CYC + 2);
      check_int("release_level", int'(key_level), 0);

      // Release bounce.
      hold(1'b0, 1'b1, 12);
      kp0 = kp_seen;
      rp0 = rp_seen;
      hold(1'b1, 1'b1, 2);
      hold(1'b0, 1'b1, 2);
      edge_ref = cyc + 2;
      hold(1'b1, 1'b1, 12);
      settle();
      check_int("rel_bounce_no_repress", kp_seen - kp0, 0);
      check_int("rel_bounce_release_count", rp_seen - rp0, 1);
      check_int("rel_bounce_latency", rp_cyc - edge_ref, DB_CYC + 2);

      // Press bounce: widths 1..3 cycles for about 20 cycles.
      kp0 = kp_seen;
      v = 1'b0;
      budget = 0;
      while (budget < 20) begin
         int w;
         w = $urandom_range(1, 3);
         hold(v, 1'b1, w);
         budget += w;
         v = ~v;
      end
      hold(1'b1, 1'b1, 12);
      settle();
      check_int("bounce_no_press", kp_seen - kp0, 0);
      check_int("bounce_level", int'(key_level), 0);

      // Long press.
      kp0 = kp_seen;
      lp0 = lp_seen;
      hold(1'b0, 1'b1, 50);
      settle();
      check_int("long_press_one_key_pulse", kp_seen - kp0, 1);
`ifdef KEY_LONG_PRESS_EN
      check_int("long_pulse_count", lp_seen - lp0, 1);
      check_int("long_pulse_delay", lp_cyc - kp_cyc, LP_CYC);
`else
      check_int("long_pulse_absent", lp_seen - lp0, 0);
`endif
      hold(1'b1, 1'b1, 12);

      // Reset mid-press, button still held afterwards.
      hold(1'b0, 1'b1, 10);
      step(1'b0, 1'b0);
      #1;
      check_int("rst_async_level", int'(key_level), 0);
      check_int("rst_async_pulse", int'(key_pulse), 0);
      hold(1'b0, 1'b0, 2);
      kp0 = kp_seen;
      edge_ref = cyc + 2;
      hold(1'b0, 1'b1, 12);
      settle();
      check_int("rst_requalify_count", kp_seen - kp0, 1);
      check_int("rst_requalify_latency", kp_cyc - edge_ref, DB_CYC + 2);
      hold(1'b1, 1'b1, 12);

      // Random runs with occasional resets.
      for (int i = 0; i < 300; i++) begin
         v = logic'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) hold(v, 1'b0, 2);
         hold(v, 1'b1, $urandom_range(1, 8));
      end
      hold(1'b1, 1'b1, 12);
      settle();
      check_int("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces a raw mechanical push-button and turns it into clean single-cycle event pulses for the stopwatch datapath. It sits directly upstream of `timer`: `key_pulse` drives the timer's `start` input, and `long_pulse` is available as a clear request. It contains a 2-flop synchronizer, a debounce counter and a 4-state FSM.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, default 20: required stable time in ms.
- `LONG_PRESS_MS`, default 1000: hold time for a long press; used only with `KEY_LONG_PRESS_EN`.
- `KEY_ACTIVE_LOW`, default 1: when 1, a raw `key` value of 0 means pressed.
- `clk` input, 1 bit: single system clock; all logic on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `key` input, 1 bit: raw, asynchronous, bouncing button.
- `key_level` output, 1 bit: debounced pressed state, 1 = pressed.
- `key_pulse` output, 1 bit: one-cycle pulse on a debounced press.
- `release_pulse` output, 1 bit: one-cycle pulse on a debounced release.
- `long_pulse` output, 1 bit: one-cycle pulse once per press after `LONG_PRESS_MS` of hold.

## Operation
- `key` is normalised to pressed = 1 and then passed through two synchronizer flops, giving `k_s`.
  - Both flops reset to the released value.
- Derived constants:
  - `DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS`.
  - `LP_CYC = CLK_FREQ_HZ/1000*LONG_PRESS_MS`.
  - Both must be ≥ 1.
- The counter is `$clog2(max(DB_CYC, LP_CYC)+1)` bits wide and saturates rather than wrapping.
- FSM states and transitions:
  - IDLE: if `k_s`=1, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: if `k_s`=0, go to IDLE with no output. If `k_s`=1, increment the counter; when it reaches `DB_CYC-1`, go to PRESSED, pulse `key_pulse` and clear the counter.
  - PRESSED: while `k_s`=1, increment the counter; at `LP_CYC-1`, pulse `long_pulse` once. After that the counter saturates, so there is no repeat. If `k_s`=0, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: if `k_s`=1, go back to PRESSED with no new `key_pulse`, and keep the long-press count cleared. If `k_s`=0, increment the counter; at `DB_CYC-1`, go to IDLE and pulse `release_pulse`.
- `key_level` is 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
- All outputs are registered.
- The three pulses are mutually exclusive by construction.

## Timing
- Reset values:
  - State = IDLE; counter = 0.
  - `key_level`, `key_pulse`, `release_pulse` and `long_pulse` = 0.
- Press latency: if `key` is pressed stably before clock edge E, `key_pulse` is high for exactly the one cycle after edge E+2+`DB_CYC`.
  - 2 cycles are synchronizer delay; `DB_CYC` is the debounce time.
  - `key_level` rises in the same cycle as `key_pulse`.
- Release latency is symmetric: `release_pulse` and `key_level` falling coincide, `DB_CYC`+2 cycles after a stable release.
- Bounce rejection: any glitch shorter than `DB_CYC` cycles causes no pulse and restarts the count.
- `long_pulse` comes `LP_CYC` cycles after the PRESSED entry cycle.
- Reset asserted mid-press forces IDLE asynchronously. After release of reset, a button still held must re-qualify through the full debounce time and then produces one `key_pulse`.
- There is no handshake: the consumer samples the pulses on `clk`.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- Defined: long-press counting is active and `long_pulse` behaves as above.
- Undefined: the long-press logic is not synthesized, `long_pulse` is tied to 0, the counter width uses `DB_CYC` only, and PRESSED does not count.

## Structure
- Shared package `key_pkg` holds:
  - the state enum `key_state_t` (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the `ms_to_cyc()` constant function;
  - the default `DEBOUNCE_MS` and `LONG_PRESS_MS`.
- One sub-module, `sync2`: a generic 2-flop synchronizer with a reset-value parameter, reusable for the other board inputs.
- The FSM and counter stay in `key_debounce`.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1000, `DEBOUNCE_MS`=4, `LONG_PRESS_MS`=20 and `KEY_ACTIVE_LOW`=1, giving `DB_CYC`=4 and `LP_CYC`=20.
- Clean press: `key` 1→0 and held → exactly one `key_pulse`, 6 cycles after the first edge sampling 0; `key_level`=1 in the same cycle.
- Bounce: `key` toggled 0/1 with 1–3 cycle widths for 20 cycles, then 1 → no pulses and `key_level` stays 0.
- Release bounce: after a press, `key` goes to 1 for 2 cycles, then 0, then 1 stable → no second `key_pulse`; one `release_pulse` 6 cycles after the final stable 1.
- Long press (`KEY_LONG_PRESS_EN` defined): hold 50 cycles → one `key_pulse`, then one `long_pulse` 20 cycles later, no repeat; with the macro undefined, `long_pulse` stays 0.
- Reset mid-press: `rst`=0 while PRESSED → all outputs 0 immediately; `rst`=1 with `key` still 0 → a new `key_pulse` 6 cycles later.
- Reset values: hold `rst`=0 with `key` toggling → all outputs remain 0.
